// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline-boundary registers (D/E, E/M, M/W).
//   Provides the reset PC, register-index constants, the per-stage control
//   bundle and a small decoder that turns reset/stall/flush into the single
//   action a stage register performs on a given clock edge.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          REG_W            = 5;
  localparam logic [REG_W-1:0] REG_ZERO    = 5'd0;

  // Per-stage control bundle as driven by the hazard unit.
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

  // The one action a stage register takes on a clock edge.
  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_FLUSH = 2'd1,
    OP_HOLD  = 2'd2,
    OP_LOAD  = 2'd3
  } stage_op_t;

  // Priority: reset (active-low), then flush, then stall, then load.
  // Flush wins over stall so a squashed instruction can never be held.
  function automatic stage_op_t decode_op(input logic reset, input stage_ctrl_t ctrl);
    stage_op_t op;
    if (!reset) begin
      op = OP_RESET;
    end else if (ctrl.flush) begin
      op = OP_FLUSH;
    end else if (ctrl.stall) begin
      op = OP_HOLD;
    end else begin
      op = OP_LOAD;
    end
    return op;
  endfunction

  // True when the edge will leave a bubble in the register: an explicit
  // flush, or a load of an invalid upstream slot. A hold keeps whatever is
  // there and does not create a new bubble.
  function automatic logic makes_bubble(input stage_op_t op, input logic in_valid);
    return (op == OP_FLUSH) || ((op == OP_LOAD) && !in_valid);
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_sat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_sat_cnt
//   CNT_W-wide saturating event counter used for stage performance counters.
//   Counts up by one on each edge with inc=1, sticks at all-ones, and clears
//   to zero on clr=1 (clr beats inc) or on the active-low synchronous reset.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   synchronous active-low reset
//   clr    in   synchronous clear, priority over inc
//   inc    in   count enable
//   cnt    out  current count (registered)
// -----------------------------------------------------------------------------
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  // Counter register stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= '0;
    end else if (inc) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign cnt = cnt_p1;

endmodule : pipe_sat_cnt

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline-boundary register (one instance per D/E, E/M, M/W
//   boundary). Carries valid, PC, destination register index and N_FIELDS
//   payload fields of DATA_W bits. Purely registered: every output comes
//   straight from a flop.
//
//   Edge priority: reset (active-low) > flush > stall > load.
//     reset : valid=0, pc=RESET_PC, a3=0, data=0, counters cleared
//     flush : bubble (valid=0, a3=0, data=0) but pc follows in_pc so
//             exception / delay-slot logic still sees a PC
//     stall : hold everything
//     load  : capture inputs; an invalid slot is captured as a bubble
//   A bubble always carries a3=0 so it can never forward or write back.
//
// Optional build macro
//   PIPE_STAGE_REG_PERF_EN : adds perf_clr input and stall_cnt / bubble_cnt
//                            saturating counters. Without it those ports and
//                            their logic are absent; the datapath is unchanged.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous active-low reset
//   stall       in   hold current contents
//   flush       in   insert bubble (overrides stall)
//   in_valid    in   upstream slot valid
//   in_pc       in   upstream PC (32)
//   in_a3       in   upstream destination register (5)
//   in_data     in   packed payload, field k at [k*DATA_W +: DATA_W]
//   perf_clr    in   (PERF_EN) clear both counters, beats increment
//   stall_cnt   out  (PERF_EN) cycles spent stalled (not flushed)
//   bubble_cnt  out  (PERF_EN) edges that left a bubble in the register
//   out_valid   out  registered valid
//   out_pc      out  registered PC
//   out_a3      out  registered destination register
//   out_data    out  registered payload
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          N_FIELDS = 4,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [REG_W-1:0]           in_a3,
  input  logic [N_FIELDS*DATA_W-1:0] in_data,
`ifdef PIPE_STAGE_REG_PERF_EN
  input  logic                       perf_clr,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt,
`endif
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [REG_W-1:0]           out_a3,
  output logic [N_FIELDS*DATA_W-1:0] out_data
);

  localparam int PAYLOAD_W = N_FIELDS * DATA_W;

  stage_ctrl_t ctrl_p0;
  stage_op_t   op_p0;

  logic                 valid_p1;
  logic [31:0]          pc_p1;
  logic [REG_W-1:0]     a3_p1;
  logic [PAYLOAD_W-1:0] data_p1;

  assign ctrl_p0 = '{stall: stall, flush: flush};

  always_comb begin
    op_p0 = decode_op(reset, ctrl_p0);
  end

  // Stage register: p0 (upstream) -> p1 (outputs)
  always_ff @(posedge clk) begin
    case (op_p0)
      OP_RESET: begin
        valid_p1 <= 1'b0;
        pc_p1    <= RESET_PC;
        a3_p1    <= REG_ZERO;
        data_p1  <= '0;
      end
      OP_FLUSH: begin
        valid_p1 <= 1'b0;
        pc_p1    <= in_pc;
        a3_p1    <= REG_ZERO;
        data_p1  <= '0;
      end
      OP_HOLD: begin
        valid_p1 <= valid_p1;
        pc_p1    <= pc_p1;
        a3_p1    <= a3_p1;
        data_p1  <= data_p1;
      end
      OP_LOAD: begin
        valid_p1 <= in_valid;
        pc_p1    <= in_pc;
        // An invalid slot is squashed on entry so a3/data never leak.
        a3_p1    <= in_valid ? in_a3 : REG_ZERO;
        data_p1  <= in_valid ? in_data : '0;
      end
    endcase
  end

  assign out_valid = valid_p1;
  assign out_pc    = pc_p1;
  assign out_a3    = a3_p1;
  assign out_data  = data_p1;

`ifdef PIPE_STAGE_REG_PERF_EN
  logic stall_inc_p0;
  logic bubble_inc_p0;

  // Only a genuine hold counts as a stall; a stall under flush is a bubble.
  assign stall_inc_p0  = (op_p0 == OP_HOLD);
  assign bubble_inc_p0 = makes_bubble(op_p0, in_valid);

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (stall_inc_p0),
    .cnt   (stall_cnt)
  );

  pipe_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (perf_clr),
    .inc   (bubble_inc_p0),
    .cnt   (bubble_cnt)
  );
`endif

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Self-checking bench for pipe_stage_reg. A behavioural model tracks what
//   the outputs must hold after each edge; a compare process checks the DUT
//   against it every cycle. Directed steps pin the model with literal values,
//   then randomized stimulus exercises all control combinations.
//   With PIPE_STAGE_REG_PERF_EN defined a second instance with CNT_W=2
//   exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int NF   = 4;
  localparam int DW   = 32;
  localparam int W    = NF * DW;
  localparam int CW   = 16;
  localparam int CW_S = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [4:0]    in_a3;
  logic [W-1:0]  in_data;
  logic          perf_clr;

  logic          out_valid;
  logic [31:0]   out_pc;
  logic [4:0]    out_a3;
  logic [W-1:0]  out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [CW-1:0]   stall_cnt, bubble_cnt;
  logic            s_valid;
  logic [31:0]     s_pc;
  logic [4:0]      s_a3;
  logic [W-1:0]    s_data;
  logic [CW_S-1:0] s_stall_cnt, s_bubble_cnt;
`endif

  pipe_stage_reg #(
    .N_FIELDS (NF),
    .DATA_W   (DW),
    .RESET_PC (32'h0000_3000),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_a3      (in_a3),
    .in_data    (in_data),
`ifdef PIPE_STAGE_REG_PERF_EN
    .perf_clr   (perf_clr),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_a3     (out_a3),
    .out_data   (out_data)
  );

`ifdef PIPE_STAGE_REG_PERF_EN
  pipe_stage_reg #(
    .N_FIELDS (NF),
    .DATA_W   (DW),
    .RESET_PC (32'h0000_3000),
    .CNT_W    (CW_S)
  ) dut_s (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_a3      (in_a3),
    .in_data    (in_data),
    .perf_clr   (perf_clr),
    .stall_cnt  (s_stall_cnt),
    .bubble_cnt (s_bubble_cnt),
    .out_valid  (s_valid),
    .out_pc     (s_pc),
    .out_a3     (s_a3),
    .out_data   (s_data)
  );
`endif

  // Behavioural model: expected register contents after each edge.
  bit           m_known = 1'b0;
  logic         m_valid;
  logic [31:0]  m_pc;
  logic [4:0]   m_a3;
  logic [W-1:0] m_data;
  int           m_sc, m_bc, m_sc_s, m_bc_s;

  function automatic int sat_add(input int v, input int width);
    int mx;
    mx = (1 << width) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_pc    = 32'h0000_3000;
      m_a3    = 5'd0;
      m_data  = '0;
      m_sc = 0; m_bc = 0; m_sc_s = 0; m_bc_s = 0;
    end else begin
      if (flush) begin
        m_valid = 1'b0; m_a3 = 5'd0; m_data = '0; m_pc = in_pc;
      end else if (!stall) begin
        m_valid = in_valid;
        m_pc    = in_pc;
        m_a3    = in_valid ? in_a3 : 5'd0;
        m_data  = in_valid ? in_data : '0;
      end
      if (perf_clr) begin
        m_sc = 0; m_bc = 0; m_sc_s = 0; m_bc_s = 0;
      end else begin
        if (stall && !flush) begin
          m_sc   = sat_add(m_sc, CW);
          m_sc_s = sat_add(m_sc_s, CW_S);
        end
        if (flush || (!stall && !in_valid)) begin
          m_bc   = sat_add(m_bc, CW);
          m_bc_s = sat_add(m_bc_s, CW_S);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("model_valid", W'(out_valid), W'(m_valid));
      check("model_pc",    W'(out_pc),    W'(m_pc));
      check("model_a3",    W'(out_a3),    W'(m_a3));
      check("model_data",  out_data,      m_data);
      if (!out_valid) check("bubble_a3_zero", W'(out_a3), '0);
`ifdef PIPE_STAGE_REG_PERF_EN
      check("model_stall_cnt",    W'(stall_cnt),    W'(m_sc));
      check("model_bubble_cnt",   W'(bubble_cnt),   W'(m_bc));
      check("model_s_valid",      W'(s_valid),      W'(m_valid));
      check("model_s_pc",         W'(s_pc),         W'(m_pc));
      check("model_s_a3",         W'(s_a3),         W'(m_a3));
      check("model_s_data",       s_data,           m_data);
      check("model_s_stall_cnt",  W'(s_stall_cnt),  W'(m_sc_s));
      check("model_s_bubble_cnt", W'(s_bubble_cnt), W'(m_bc_s));
`endif
    end
  end

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int k = 0; k < NF; k++) d[k*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic rand_inputs();
    in_valid = 1'($urandom);
    in_pc    = $urandom;
    in_a3    = 5'($urandom);
    in_data  = rand_data();
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [4:0] a3, input logic [W-1:0] d);
    check({tag, "_valid"}, W'(out_valid), W'(v));
    check({tag, "_pc"},    W'(out_pc),    W'(pc));
    check({tag, "_a3"},    W'(out_a3),    W'(a3));
    check({tag, "_data"},  out_data,      d);
  endtask

  logic [W-1:0] beef;

  initial begin
    beef     = W'(32'hDEADBEEF);
    reset    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    perf_clr = 1'b0;
    rand_inputs();

    // Reset for one cycle.
    @(negedge clk);
    expect_out("reset", 1'b0, 32'h0000_3000, 5'd0, '0);

    // Load a valid slot; visible one edge later.
    reset = 1'b1; in_valid = 1'b1; in_pc = 32'h3004; in_a3 = 5'd8; in_data = beef;
    @(negedge clk);
    expect_out("load", 1'b1, 32'h3004, 5'd8, beef);

    // Stall three cycles while inputs churn.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      @(negedge clk);
      expect_out("stall", 1'b1, 32'h3004, 5'd8, beef);
    end
`ifdef PIPE_STAGE_REG_PERF_EN
    check("stall_cnt_3", W'(stall_cnt), W'(3));
    check("s_stall_cnt_3", W'(s_stall_cnt), W'(3));
`endif
    // Two more stalls: narrow counter saturates.
    repeat (2) begin rand_inputs(); @(negedge clk); end
    expect_out("stall5", 1'b1, 32'h3004, 5'd8, beef);
`ifdef PIPE_STAGE_REG_PERF_EN
    check("stall_cnt_5", W'(stall_cnt), W'(5));
    check("s_stall_cnt_sat", W'(s_stall_cnt), W'(3));
`endif
    // Clear while stalling: clear wins.
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
`ifdef PIPE_STAGE_REG_PERF_EN
    check("stall_cnt_clr", W'(stall_cnt), W'(0));
    check("s_stall_cnt_clr", W'(s_stall_cnt), W'(0));
`endif

    // Stall and flush together: flush wins, PC tracks input.
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3010; in_a3 = 5'd7; in_data = beef;
    @(negedge clk);
    expect_out("flush", 1'b0, 32'h3010, 5'd0, '0);
`ifdef PIPE_STAGE_REG_PERF_EN
    check("bubble_cnt_flush", W'(bubble_cnt), W'(1));
    check("stall_cnt_flush", W'(stall_cnt), W'(0));
`endif

    // Load of an invalid slot with nonzero a3.
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 32'h3020; in_a3 = 5'd31;
    @(negedge clk);
    expect_out("invalid_load", 1'b0, 32'h3020, 5'd0, '0);
`ifdef PIPE_STAGE_REG_PERF_EN
    check("bubble_cnt_invalid", W'(bubble_cnt), W'(2));
`endif

    // Reset in the middle of a stall; nothing held survives.
    in_valid = 1'b1; in_pc = 32'h3030; in_a3 = 5'd3; in_data = beef;
    @(negedge clk);
    expect_out("preload", 1'b1, 32'h3030, 5'd3, beef);
    stall = 1'b1; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rand_inputs();
    @(negedge clk);
    expect_out("reset_in_stall", 1'b0, 32'h0000_3000, 5'd0, '0);
    stall = 1'b0;

    // Randomized phase, checked by the per-cycle compare.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      reset    = ($urandom_range(0, 49) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      perf_clr = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
